dcc_wait_gen: RTL and testbench

// - Bus wait-state generator for the SH-2 external bus. Drives WTIN_N into the DCC decoder, which forwards it as WAIT_N.
// - Decodes region from A/CSn using the same map as DCC and holds WAIT low for a per-region cycle count.
// - For CS2 accesses, holds WAIT low until the external device reports ready.

---
 rtl/dcc_wait_gen.sv | 156 +++++++++++++++
 tb/tb_dcc_wait_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dcc_wait_gen.sv
// dcc_wait_gen: SH-2 external bus wait-state generator driving WTIN_N into the DCC decoder.
// Define DCC_WAIT_TIMEOUT_EN to add the CS2 EXT_RDY timeout counter and TIMEOUT pulse.
module dcc_wait_gen #(
    parameter int unsigned CW          = 8,
    parameter int unsigned ROM_WAIT    = 4,
    parameter int unsigned SMPC_WAIT   = 8,
    parameter int unsigned SRAM_WAIT   = 2,
    parameter int unsigned DRAM_WAIT   = 1,
    parameter int unsigned CS1_WAIT    = 3,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic [23:0] A,
    input  logic        BS_N,
    input  logic        CS0_N,
    input  logic        CS1_N,
    input  logic        CS2_N,
    input  logic        RD_N,
    input  logic [1:0]  WE_N,
    input  logic        EXT_RDY,
    output logic        WTIN_N,
    output logic        BUSY,
    output logic        TIMEOUT
);

    localparam int unsigned CNT_MAX = (CW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CW) - 32'd1);
    localparam bit CFG_OK = (ROM_WAIT <= CNT_MAX) && (SMPC_WAIT <= CNT_MAX) &&
                            (SRAM_WAIT <= CNT_MAX) && (DRAM_WAIT <= CNT_MAX) &&
                            (CS1_WAIT <= CNT_MAX) && (TIMEOUT_CYC <= CNT_MAX);

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] ROM_N  = CW'(ROM_WAIT);
    localparam logic [CW-1:0] SMPC_N = CW'(SMPC_WAIT);
    localparam logic [CW-1:0] SRAM_N = CW'(SRAM_WAIT);
    localparam logic [CW-1:0] DRAM_N = CW'(DRAM_WAIT);
    localparam logic [CW-1:0] CS1_N_ = CW'(CS1_WAIT);

    typedef enum logic [1:0] {IDLE, COUNT, EXTWAIT, RELEASE} state_t;

    state_t        state, state_nx, launch_state;
    logic [CW-1:0] cnt, cnt_nx, start_cnt;
    logic          start_req, strobes_idle;
    logic          unused_addr;

    assign unused_addr  = &{1'b0, A[18:0]};
    assign strobes_idle = RD_N && (WE_N == 2'b11);
    assign BUSY         = (state != IDLE);

    // The hex value on A carries the decode-map bit positions directly; bit 24 lies above the port and reads as 0.
    always_comb begin
        start_cnt    = '0;
        start_req    = !BS_N && !(CS0_N && CS1_N && CS2_N);
        launch_state = IDLE;
        if (!CS0_N) begin
            if (A[23:20] == 4'b0000)       start_cnt = ROM_N;
            else if (A[23:19] == 5'b00010) start_cnt = SMPC_N;
            else if (A[23:19] == 5'b00011) start_cnt = SRAM_N;
            else if (A[23:21] == 3'b001)   start_cnt = DRAM_N;
        end else if (!CS1_N) begin
            start_cnt = CS1_N_;
        end
        if (start_req) begin
            if (CS0_N && CS1_N)         launch_state = EXTWAIT;
            else if (start_cnt == '0)   launch_state = RELEASE;
            else                        launch_state = COUNT;
        end
    end

`ifdef DCC_WAIT_TIMEOUT_EN
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] tc, tc_nx;
    logic          timeout_nx;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
`ifdef DCC_WAIT_TIMEOUT_EN
        tc_nx      = tc;
        timeout_nx = 1'b0;
`endif
        if (CE_R) begin
            unique case (state)
                IDLE: begin
                    state_nx = launch_state;
                    cnt_nx   = start_cnt;
`ifdef DCC_WAIT_TIMEOUT_EN
                    tc_nx    = '0;
`endif
                end
                COUNT: begin
                    cnt_nx = (cnt != '0) ? cnt - ONE : '0;
                    if (cnt <= ONE) state_nx = RELEASE;
                end
                EXTWAIT: begin
`ifdef DCC_WAIT_TIMEOUT_EN
                    if (EXT_RDY) begin
                        state_nx = RELEASE;
                    end else if (tc == TC_LAST) begin
                        state_nx   = RELEASE;
                        timeout_nx = 1'b1;
                    end else begin
                        tc_nx = (tc == '1) ? tc : tc + ONE;
                    end
`else
                    if (EXT_RDY) state_nx = RELEASE;
`endif
                end
                RELEASE: begin
                    if (strobes_idle) begin
                        state_nx = launch_state;
                        cnt_nx   = start_cnt;
`ifdef DCC_WAIT_TIMEOUT_EN
                        tc_nx    = '0;
`endif
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            WTIN_N <= 1'b1;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            WTIN_N <= !((state_nx == COUNT) || (state_nx == EXTWAIT));
        end
    end

`ifdef DCC_WAIT_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tc      <= '0;
            TIMEOUT <= 1'b0;
        end else begin
            tc      <= tc_nx;
            TIMEOUT <= timeout_nx;
        end
    end
`else
    assign TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        assert (CFG_OK) else $error("dcc_wait_gen: wait/timeout parameter exceeds 2^CW-1");
    end

endmodule

// File: tb/tb_dcc_wait_gen.sv
// tb_dcc_wait_gen: directed bench with a transaction-level wait model checked every CLK.
module tb_dcc_wait_gen;

    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce_r = 1'b0;
    logic [23:0] a = '0;
    logic        bs_n = 1'b1, cs0_n = 1'b1, cs1_n = 1'b1, cs2_n = 1'b1, rd_n = 1'b1;
    logic [1:0]  we_n = 2'b11;
    logic        ext_rdy = 1'b0;
    logic        wtin_n, busy, timeout;

    int checks = 0, failures = 0;
    int to_pulses = 0;
    bit saw_idle = 0, saw_low = 0;
    int n;

    dcc_wait_gen #(.TIMEOUT_CYC(TO_CYC)) dut (
        .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .A(a), .BS_N(bs_n),
        .CS0_N(cs0_n), .CS1_N(cs1_n), .CS2_N(cs2_n), .RD_N(rd_n), .WE_N(we_n),
        .EXT_RDY(ext_rdy), .WTIN_N(wtin_n), .BUSY(busy), .TIMEOUT(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction owes N low bus periods (or an EXT_RDY/timeout wait), then holds busy until strobes clear.
    bit m_busy = 0, m_low = 0, m_ext = 0, m_to = 0;
    int m_left = 0, m_elapsed = 0;

    function automatic int region_wait(input logic [23:0] addr);
        if (addr < 24'h100000)      return 4;
        else if (addr < 24'h180000) return 8;
        else if (addr < 24'h200000) return 2;
        else if (addr < 24'h400000) return 1;
        else                        return 0;
    endfunction

    task automatic model_start();
        if (!cs0_n)      begin m_ext = 0; m_left = region_wait(a); end
        else if (!cs1_n) begin m_ext = 0; m_left = 3; end
        else if (!cs2_n) begin m_ext = 1; m_elapsed = 0; end
        else return;
        m_busy = 1;
        m_low  = m_ext || (m_left > 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_low = 0; m_ext = 0; m_to = 0; m_left = 0; m_elapsed = 0;
        end else begin
            m_to = 0;
            if (ce_r) begin
                if (!m_busy) begin
                    if (!bs_n) model_start();
                end else if (m_low) begin
                    if (m_ext) begin
                        m_elapsed++;
                        if (ext_rdy) m_low = 0;
`ifdef DCC_WAIT_TIMEOUT_EN
                        else if (m_elapsed == TO_CYC) begin m_low = 0; m_to = 1; end
`endif
                    end else begin
                        m_left--;
                        if (m_left == 0) m_low = 0;
                    end
                end else if (rd_n && we_n == 2'b11) begin
                    m_busy = 0;
                    if (!bs_n) model_start();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_wtin_n", wtin_n, !m_low);
        chk("model_busy", busy, m_busy);
        chk("model_timeout", timeout, m_to);
        if (timeout === 1'b1) to_pulses++;
        if (busy === 1'b0) saw_idle = 1;
        if (wtin_n === 1'b0) saw_low = 1;
    end

    task automatic step();
        @(negedge clk); ce_r = 1'b1;
        @(negedge clk); ce_r = 1'b0;
    endtask

    task automatic count_low(input int limit, output int cnt);
        cnt = 0;
        while (wtin_n == 1'b0 && cnt < limit) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wtin_n", wtin_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        step(); step();

        // BIOS ROM read: 4 waits, busy until RD_N rises
        a = 24'h000100; cs0_n = 0; rd_n = 0; bs_n = 0; step(); bs_n = 1;
        count_low(20, n);
        chk("rom_waits", n, 4);
        step();
        chk("rom_busy_strobe_held", busy, 1'b1);
        rd_n = 1; cs0_n = 1; step();
        chk("rom_idle", busy, 1'b0);

        // SMPC write followed back-to-back by SRAM
        a = 24'h100000; cs0_n = 0; we_n = 2'b00; bs_n = 0; step(); bs_n = 1;
        count_low(30, n);
        chk("smpc_waits", n, 8);
        saw_idle = 0;
        we_n = 2'b11; bs_n = 0; a = 24'h180000; step(); bs_n = 1; we_n = 2'b00;
        count_low(30, n);
        chk("sram_waits", n, 2);
        chk("b2b_no_idle", saw_idle, 1'b0);
        we_n = 2'b11; cs0_n = 1; step();
        chk("sram_idle", busy, 1'b0);

        // CS0 unmapped: zero wait
        saw_low = 0;
        a = 24'h400000; cs0_n = 0; rd_n = 0; bs_n = 0; step(); bs_n = 1;
        chk("unmapped_wtin_n", wtin_n, 1'b1);
        chk("unmapped_busy", busy, 1'b1);
        rd_n = 1; cs0_n = 1; step();
        chk("unmapped_idle", busy, 1'b0);
        chk("unmapped_never_low", saw_low, 1'b0);

        // CS1 beats CS2; stray BS_N during COUNT/RELEASE ignored
        a = 24'h000000; cs1_n = 0; cs2_n = 0; rd_n = 0; bs_n = 0; step();
        count_low(20, n);
        chk("cs1_waits", n, 3);
        step();
        chk("cs1_release_held", busy, 1'b1);
        bs_n = 1; rd_n = 1; cs1_n = 1; cs2_n = 1; step();
        chk("cs1_idle", busy, 1'b0);

        // CS0 beats CS1: DRAM single wait
        a = 24'h200000; cs0_n = 0; cs1_n = 0; rd_n = 0; bs_n = 0; step(); bs_n = 1;
        count_low(20, n);
        chk("dram_waits", n, 1);
        rd_n = 1; cs0_n = 1; cs1_n = 1; step();

        // CS2 with EXT_RDY on the 10th bus cycle
        to_pulses = 0;
        cs2_n = 0; rd_n = 0; ext_rdy = 0; bs_n = 0; step(); bs_n = 1;
        n = 0;
        repeat (9) begin
            if (wtin_n == 1'b0) n++;
            step();
        end
        if (wtin_n == 1'b0) n++;
        ext_rdy = 1; step();
        chk("ext_waits", n, 10);
        chk("ext_released", wtin_n, 1'b1);
        ext_rdy = 0; rd_n = 1; cs2_n = 1; step();
        chk("ext_idle", busy, 1'b0);
        chk("ext_no_timeout", to_pulses, 0);

        // CS2 with EXT_RDY never asserted
        to_pulses = 0;
        cs2_n = 0; rd_n = 0; bs_n = 0; step(); bs_n = 1;
        count_low(40, n);
`ifdef DCC_WAIT_TIMEOUT_EN
        chk("timeout_waits", n, TO_CYC);
        step();
        chk("timeout_pulses", to_pulses, 1);
`else
        chk("notimeout_waits", n, 40);
        chk("notimeout_still_low", wtin_n, 1'b0);
        chk("notimeout_pulses", to_pulses, 0);
        ext_rdy = 1; step(); ext_rdy = 0;
`endif
        rd_n = 1; cs2_n = 1; step();
        chk("to_idle", busy, 1'b0);

        // Reset mid-COUNT, then a full-count restart
        a = 24'h000100; cs0_n = 0; rd_n = 0; bs_n = 0; step(); bs_n = 1; step();
        #2 rst_n = 0;
        #1;
        chk("midrst_wtin_n", wtin_n, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1;
        bs_n = 0; step(); bs_n = 1;
        count_low(20, n);
        chk("restart_waits", n, 4);
        rd_n = 1; cs0_n = 1; step();
        chk("restart_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
